adc_frame_dispatcher: RTL and testbench
=======================================

ADC_FRAME_DISPATCHER -- requirements
Module: adc_frame_dispatcher

Interface
REQ-001 The module SHALL have parameter NUM_FFT, default 4: number of downstream FFT engines (2..8).
REQ-002 The module SHALL have parameter FRAME_LEN, default 1024: samples per FFT frame (power of two, 8..4096).
REQ-003 The module SHALL have parameter ADC_W, default 12: ADC sample width.
REQ-004 The module SHALL have parameter OUT_W, default 16: output sample width; OUT_W >= ADC_W is an elaboration-time check.
REQ-005 The module SHALL have parameter OFFSET_BINARY, default 1: 1 = ADC data is unsigned offset-binary, 0 = two's complement.
REQ-006 The module SHALL have port clk, input, 1: the single clock (system clock domain).
REQ-007 The module SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-008 The module SHALL have port enable, input, 1: permits new frames to start.
REQ-009 The module SHALL have port sample_valid, input, 1: one-cycle strobe, ADC sample present.
REQ-010 The module SHALL have port sample_data, input, ADC_W: ADC sample.
REQ-011 The module SHALL have port fft_done, input, NUM_FFT: per-engine one-cycle "frame processed" pulse.
REQ-012 The module SHALL have port write_active, output, NUM_FFT: per-engine input-stream-active (one-hot or zero).
REQ-013 The module SHALL have port out_valid, output, 1: converted sample strobe.
REQ-014 The module SHALL have port out_real, output, OUT_W: signed converted sample.
REQ-015 The module SHALL have port out_sel, output, clog2(NUM_FFT): index of the engine being fed.
REQ-016 The module SHALL have port frame_start / frame_end, output, 1 each: pulses coincident with the first / last out_valid of a frame.
REQ-017 The module SHALL have port fft_busy, output, NUM_FFT: engine holds an unprocessed frame.
REQ-018 The module SHALL have port overrun_count, output, 16: saturating count of samples dropped while no engine was free.

Function
REQ-019 States SHALL be: IDLE, SEEK, STREAM.
REQ-020 IDLE -> SEEK when enable=1; SEEK with enable=0 -> IDLE.
REQ-021 In SEEK, a rotating-priority search starting at (last engine + 1) mod NUM_FFT SHALL pick the first engine with fft_busy=0; if one is found, cur latches it, the sample counter clears, and the state becomes STREAM on the next cycle.
REQ-022 Samples arriving in IDLE or SEEK SHALL be dropped; overrun_count increments (saturating at 16'hFFFF) only for samples dropped in SEEK while all engines are busy.
REQ-023 In STREAM, write_active[cur]=1 and all other bits are 0; each sample_valid produces, one cycle later, out_valid=1, out_real=converted sample, and out_sel=cur (fixed latency 1).
REQ-024 The sample accepted with counter = FRAME_LEN-1 SHALL be the last sample of the frame: its output cycle has frame_end=1, write_active drops after that cycle, fft_busy[cur] sets, and the state becomes SEEK.
REQ-025 Deasserting enable mid-frame SHALL NOT truncate the frame: the frame completes, then SEEK -> IDLE.
REQ-026 Conversion: when OFFSET_BINARY=1, out_real = sign-extend(sample_data - 2^(ADC_W-1)); when OFFSET_BINARY=0, out_real = sign-extend(sample_data).
REQ-027 fft_done[i] SHALL clear fft_busy[i] on the next edge; fft_done for a non-busy engine SHALL be ignored; a set and a clear of the same bit in the same cycle resolve to set.
REQ-028 Frames SHALL be delivered with no gaps or duplicates: exactly FRAME_LEN out_valid pulses between frame_start and frame_end inclusive.

Reset
REQ-029 Reset SHALL take effect on the next clk edge from any state, including mid-frame: state=IDLE, write_active=0, out_valid=0, frame_start=0, frame_end=0, out_real=0, out_sel=0, fft_busy=0, overrun_count=0, counter=0, and last engine = NUM_FFT-1 (so the first frame goes to engine 0).

Structure
REQ-030 The state enum and the default parameter constants SHALL live in shared package shazam_pkg.
REQ-031 The rotating free-engine search SHALL be a sub-module rr_free_picker (inputs: busy vector, start index; outputs: found flag, index).

Verification
REQ-032 Test: reset, enable=1, stream 4x1024 samples with all fft_done low -> frames go to engines 0,1,2,3, then all fft_busy=4'hF; 10 more samples -> overrun_count=10.
REQ-033 Test: after REQ-032, pulse fft_done[2] -> the next frame goes to engine 2, and engine 3 is skipped because it is busy.
REQ-034 Test: OFFSET_BINARY=1 with samples 12'h000, 12'h800, 12'hFFF -> out_real = 16'hF800, 16'h0000, 16'h07FF, each one cycle after sample_valid.
REQ-035 Test: drop enable at sample 500 of a frame -> all 1024 samples are delivered, frame_end pulses, the state reaches IDLE, and no further write_active.
REQ-036 Test: assert reset at sample 300 -> all outputs are 0 next cycle; after restart, the first frame goes to engine 0 with a full 1024 samples.
REQ-037 Test: fft_done[1] pulsed in the same cycle engine 1's frame ends -> fft_busy[1] remains 1.

Source files
------------

// File: rtl/shazam_pkg.sv
// Shared FSM encoding and default parameters for the ADC frame dispatcher.
package shazam_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEEK   = 2'd1,
      STREAM = 2'd2
   } state_t;

   localparam int DEF_NUM_FFT       = 4;
   localparam int DEF_FRAME_LEN     = 1024;
   localparam int DEF_ADC_W         = 12;
   localparam int DEF_OUT_W         = 16;
   localparam int DEF_OFFSET_BINARY = 1;

endpackage

// File: rtl/rr_free_picker.sv
// Rotating-priority search for the first non-busy engine starting at 'start'.
// Purely combinational; found=0 when every engine is busy.
module rr_free_picker
   import shazam_pkg::*;
#(
   parameter int N  = DEF_NUM_FFT,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  busy,
   input  logic [IW-1:0] start,
   output logic          found,
   output logic [IW-1:0] idx
);

   logic [IW:0] pos;

   always_comb begin
      found = 1'b0;
      idx   = '0;
      pos   = '0;
      for (int k = 0; k < N; k++) begin
         pos = {1'b0, start} + (IW+1)'(k);
         if (pos >= (IW+1)'(N)) begin
            pos = pos - (IW+1)'(N);
         end
         if (!found && !busy[pos[IW-1:0]]) begin
            found = 1'b1;
            idx   = pos[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/adc_frame_dispatcher.sv
// Splits a continuous ADC sample stream into FRAME_LEN frames, round-robin over free FFT engines.
// Converted sample out one cycle after sample_valid; no backpressure, samples are dropped (and counted) when all engines are busy.
module adc_frame_dispatcher
   import shazam_pkg::*;
#(
   parameter int NUM_FFT       = DEF_NUM_FFT,
   parameter int FRAME_LEN     = DEF_FRAME_LEN,
   parameter int ADC_W         = DEF_ADC_W,
   parameter int OUT_W         = DEF_OUT_W,
   parameter int OFFSET_BINARY = DEF_OFFSET_BINARY
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       enable,
   input  logic                       sample_valid,
   input  logic [ADC_W-1:0]           sample_data,
   input  logic [NUM_FFT-1:0]         fft_done,
   output logic [NUM_FFT-1:0]         write_active,
   output logic                       out_valid,
   output logic [OUT_W-1:0]           out_real,
   output logic [$clog2(NUM_FFT)-1:0] out_sel,
   output logic                       frame_start,
   output logic                       frame_end,
   output logic [NUM_FFT-1:0]         fft_busy,
   output logic [15:0]                overrun_count
);

   localparam int SEL_W = $clog2(NUM_FFT);
   localparam int CNT_W = $clog2(FRAME_LEN);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);
   localparam logic [SEL_W-1:0] LAST_ENG = SEL_W'(NUM_FFT - 1);

   if (OUT_W < ADC_W) begin : g_bad_out_w
      $error("adc_frame_dispatcher: OUT_W must be >= ADC_W");
   end
   if (NUM_FFT < 2 || NUM_FFT > 8) begin : g_bad_num_fft
      $error("adc_frame_dispatcher: NUM_FFT must be 2..8");
   end

   state_t             state, state_nxt;
   logic [SEL_W-1:0]   cur, last_eng, start_idx, pick_idx;
   logic               pick_found;
   logic [CNT_W-1:0]   cnt;
   logic               accept, last_sample, take, drop_busy;
   logic [NUM_FFT-1:0] set_mask;
   logic signed [ADC_W-1:0] conv;

   assign start_idx = (last_eng == LAST_ENG) ? '0 : last_eng + 1'b1;

   rr_free_picker #(.N(NUM_FFT), .IW(SEL_W)) u_picker (
      .busy  (fft_busy),
      .start (start_idx),
      .found (pick_found),
      .idx   (pick_idx)
   );

   // Offset-binary to two's complement is an MSB flip; the size cast then sign-extends.
   assign conv = (OFFSET_BINARY != 0) ? signed'({~sample_data[ADC_W-1], sample_data[ADC_W-2:0]})
                                      : signed'(sample_data);

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (enable) state_nxt = SEEK;
         SEEK:    if (!enable) state_nxt = IDLE;
                  else if (pick_found) state_nxt = STREAM;
         STREAM:  if (last_sample) state_nxt = SEEK;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      write_active = '0;
      if (state == STREAM) write_active = NUM_FFT'(1) << cur;
      accept      = (state == STREAM) && sample_valid;
      last_sample = accept && (cnt == LAST_CNT);
      take        = (state == SEEK) && enable && pick_found;
      drop_busy   = (state == SEEK) && sample_valid && !pick_found;
      set_mask    = last_sample ? (NUM_FFT'(1) << cur) : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cur           <= '0;
         last_eng      <= LAST_ENG;
         cnt           <= '0;
         fft_busy      <= '0;
         overrun_count <= '0;
         out_valid     <= 1'b0;
         out_real      <= '0;
         out_sel       <= '0;
         frame_start   <= 1'b0;
         frame_end     <= 1'b0;
      end else begin
         out_valid   <= accept;
         frame_start <= accept && (cnt == '0);
         frame_end   <= last_sample;
         if (accept) begin
            out_real <= OUT_W'(conv);
            out_sel  <= cur;
         end
         if (take) begin
            cur <= pick_idx;
            cnt <= '0;
         end else if (accept) begin
            cnt <= cnt + 1'b1;
         end
         if (last_sample) last_eng <= cur;
         // A set on frame completion wins over a same-cycle done for that engine.
         fft_busy <= (fft_busy & ~fft_done) | set_mask;
         if (drop_busy && overrun_count != 16'hFFFF) begin
            overrun_count <= overrun_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_adc_frame_dispatcher.sv
// Directed bench for adc_frame_dispatcher: stimulus pushes expected outputs, a negedge monitor pops and compares.
module tb_adc_frame_dispatcher;

   localparam int NUM_FFT   = 4;
   localparam int FRAME_LEN = 1024;

   logic        clk = 1'b0;
   logic        reset, enable, sample_valid;
   logic [11:0] sample_data;
   logic [3:0]  fft_done;
   logic [3:0]  write_active;
   logic        out_valid;
   logic [15:0] out_real;
   logic [1:0]  out_sel;
   logic        frame_start, frame_end;
   logic [3:0]  fft_busy;
   logic [15:0] overrun_count;

   adc_frame_dispatcher dut (
      .clk           (clk),
      .reset         (reset),
      .enable        (enable),
      .sample_valid  (sample_valid),
      .sample_data   (sample_data),
      .fft_done      (fft_done),
      .write_active  (write_active),
      .out_valid     (out_valid),
      .out_real      (out_real),
      .out_sel       (out_sel),
      .frame_start   (frame_start),
      .frame_end     (frame_end),
      .fft_busy      (fft_busy),
      .overrun_count (overrun_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc = cyc + 1;

   typedef struct packed {
      logic [15:0] re;
      logic [1:0]  sel;
      logic        fs;
      logic        fe;
      logic [31:0] cy;
   } exp_t;

   exp_t exp_q[$];
   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
      end
   endtask

   always @(negedge clk) begin
      if (out_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out actual=out_valid with data %h required=no output", out_real);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("out_real",    32'(out_real),    32'(e.re));
            check("out_sel",     32'(out_sel),     32'(e.sel));
            check("frame_start", 32'(frame_start), 32'(e.fs));
            check("frame_end",   32'(frame_end),   32'(e.fe));
            check("latency",     32'(cyc),         e.cy);
         end
      end
   end

   // Offset-binary reference: subtract mid-scale in plain integer arithmetic.
   function automatic logic [15:0] ref_conv(input logic [11:0] d);
      int v;
      v = int'(d) - 2048;
      return 16'(v);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_done(input logic [3:0] m);
      fft_done = m;
      tick();
      fft_done = '0;
   endtask

   task automatic wait_stream(input int eng, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (write_active != '0) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      check("write_active_sel", 32'(write_active), 32'(1) << eng);
   endtask

   task automatic run_frame(input int eng, input int seed, input int drop_at,
                            input bit done_at_end, input int abort_at);
      bit ok;
      logic [11:0] d;
      exp_t e;
      wait_stream(eng, ok);
      if (!ok) return;
      for (int i = 0; i < FRAME_LEN; i++) begin
         if (i == abort_at) begin
            sample_valid = 1'b0;
            reset = 1'b1;
            tick();
            return;
         end
         case (i)
            0:       begin d = 12'h000; e.re = 16'hF800; end
            1:       begin d = 12'h800; e.re = 16'h0000; end
            2:       begin d = 12'hFFF; e.re = 16'h07FF; end
            default: begin d = 12'((i * 37 + seed * 101) & 32'hFFF); e.re = ref_conv(d); end
         endcase
         sample_valid = 1'b1;
         sample_data  = d;
         if (i == FRAME_LEN - 1 && done_at_end) fft_done = 4'(1 << eng);
         if (i == drop_at) enable = 1'b0;
         e.sel = 2'(eng);
         e.fs  = (i == 0);
         e.fe  = (i == FRAME_LEN - 1);
         e.cy  = 32'(cyc + 1);
         exp_q.push_back(e);
         tick();
      end
      sample_valid = 1'b0;
      fft_done     = '0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=completion");
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      int stray;
      reset = 1'b1; enable = 1'b0; sample_valid = 1'b0; sample_data = '0; fft_done = '0;
      tick();
      tick();
      check("rst_out_valid",    32'(out_valid),     32'd0);
      check("rst_write_active", 32'(write_active),  32'd0);
      check("rst_fft_busy",     32'(fft_busy),      32'd0);
      check("rst_overrun",      32'(overrun_count), 32'd0);
      reset = 1'b0;
      enable = 1'b1;

      // Four frames land on engines 0..3 in order, then everything is busy.
      for (int f = 0; f < NUM_FFT; f++) run_frame(f, f, -1, 1'b0, -1);
      check("all_busy", 32'(fft_busy), 32'hF);
      for (int k = 0; k < 10; k++) begin
         sample_valid = 1'b1;
         sample_data  = 12'(k);
         tick();
      end
      sample_valid = 1'b0;
      check("overrun_10", 32'(overrun_count), 32'd10);
      check("no_stream_when_busy", 32'(write_active), 32'd0);

      // Freeing engine 2 sends the next frame there; after that 3 is busy and skipped for 0.
      pulse_done(4'b0100);
      run_frame(2, 7, -1, 1'b0, -1);
      check("busy_after_e2", 32'(fft_busy), 32'hF);
      pulse_done(4'b0001);
      run_frame(0, 9, -1, 1'b0, -1);

      // Done on engine 1 coincident with its own frame end must leave it busy.
      pulse_done(4'b0010);
      run_frame(1, 11, -1, 1'b1, -1);
      check("busy1_set_wins", 32'(fft_busy), 32'hF);
      check("overrun_still_10", 32'(overrun_count), 32'd10);

      // Enable drops mid-frame: frame completes, then no new frame even with a free engine.
      pulse_done(4'b0100);
      run_frame(2, 13, 500, 1'b0, -1);
      pulse_done(4'b1000);
      stray = 0;
      for (int k = 0; k < 20; k++) begin
         sample_valid = (k < 5);
         sample_data  = 12'h123;
         if (write_active != '0) stray++;
         tick();
      end
      sample_valid = 1'b0;
      check("idle_no_write_active", 32'(stray), 32'd0);
      check("idle_drop_not_counted", 32'(overrun_count), 32'd10);
      check("busy_after_drop", 32'(fft_busy), 32'h7);

      enable = 1'b1;
      run_frame(3, 17, -1, 1'b0, -1);

      // Reset mid-frame clears everything; next frame restarts at engine 0.
      pulse_done(4'b0010);
      run_frame(1, 19, -1, 1'b0, 300);
      check("mid_rst_out_valid",    32'(out_valid),     32'd0);
      check("mid_rst_write_active", 32'(write_active),  32'd0);
      check("mid_rst_out_real",     32'(out_real),      32'd0);
      check("mid_rst_out_sel",      32'(out_sel),       32'd0);
      check("mid_rst_frame_flags",  32'({frame_start, frame_end}), 32'd0);
      check("mid_rst_fft_busy",     32'(fft_busy),      32'd0);
      check("mid_rst_overrun",      32'(overrun_count), 32'd0);
      reset = 1'b0;
      run_frame(0, 23, -1, 1'b0, -1);
      check("busy_after_restart", 32'(fft_busy), 32'h1);

      tick();
      tick();
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
